// File: rtl/cascade_counter.sv
// cascade_counter: chained per-stage modulo up/down counter with load, wrap/saturate, werr pulse and sticky ovf
// Ports:
//   clk, resetn        clock (rising edge), asynchronous active-low reset
//   enable, up_dw      step request for stage 0, direction (1 = up) for every stage
//   clear              synchronous clear of all stages and ovf
//   wenable/wsel/wcount  single-stage load request, stage index, value
//   count              registered stage values, stage i at [i*P_BIT +: P_BIT]
//   carry              combinational per-stage terminal-step indication
//   ovf, ovf_clr       sticky chain-terminal flag and its clear
//   werr               one-cycle pulse after a rejected write
module cascade_counter #(
    parameter int P_STAGES = 4,
    parameter int P_BIT = 8,
    parameter logic [P_STAGES*P_BIT-1:0] P_BASE = {P_STAGES{8'd10}},
    parameter int P_SAT = 0,
    parameter int P_SEL_W = 2
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        enable,
    input  logic                        up_dw,
    input  logic                        clear,
    input  logic                        wenable,
    input  logic [P_SEL_W-1:0]          wsel,
    input  logic [P_BIT-1:0]            wcount,
    output logic [P_STAGES*P_BIT-1:0]   count,
    output logic [P_STAGES-1:0]         carry,
    output logic                        ovf,
    input  logic                        ovf_clr,
    output logic                        werr
);
    logic [P_STAGES-1:0] term, step;
    logic [P_STAGES*P_BIT-1:0] next_count, wr_count;
    logic [P_BIT-1:0] cur, m, sel_mod;
    logic sel_ok, valid_wr, run, chain_tc;
    always_comb begin
        sel_ok = 1'b0;
        sel_mod = '0;
        run = enable;
        term = '0;
        step = '0;
        next_count = count;
        wr_count = count;
        cur = '0;
        m = '0;
        for (int i = 0; i < P_STAGES; i++) begin
            cur = count[i*P_BIT +: P_BIT];
            m = P_BASE[i*P_BIT +: P_BIT];
            term[i] = up_dw ? cur == m - P_BIT'(1) : cur == '0;
            // ripple enable: a stage steps only when every lower stage is at its terminal
            step[i] = run;
            run = run & term[i];
            next_count[i*P_BIT +: P_BIT] = !step[i] ? cur
                : term[i] ? (up_dw ? '0 : m - P_BIT'(1))
                : (up_dw ? cur + P_BIT'(1) : cur - P_BIT'(1));
            if (wsel == P_SEL_W'(i)) begin
                sel_ok = 1'b1;
                sel_mod = m;
                wr_count[i*P_BIT +: P_BIT] = wcount;
            end
        end
        // an out-of-range index leaves sel_ok low, so the write is rejected
        valid_wr = wenable && sel_ok && wcount < sel_mod;
    end
    assign carry = (clear || valid_wr) ? '0 : step & term;
    assign chain_tc = carry[P_STAGES-1];
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
            ovf <= 1'b0;
            werr <= 1'b0;
        end else begin
            werr <= !clear && wenable && !valid_wr;
            if (clear) begin
                count <= '0;
                ovf <= 1'b0;
            end else if (valid_wr) begin
                count <= wr_count;
            end else begin
                // in saturate mode the whole chain freezes on the terminal step
                count <= (P_SAT != 0 && chain_tc) ? count : next_count;
                ovf <= chain_tc || (ovf && !ovf_clr);
            end
        end
    end
endmodule

// File: tb/tb_cascade_counter.sv
// tb_cascade_counter: directed and random checks of wrap and saturate cascade_counter instances against a mixed-radix value model
module tb_cascade_counter;
    localparam logic [11:0] base = {4'd10, 4'd6, 4'd10};
    int mm[3] = '{10, 6, 10};
    logic clk, resetn, enable, up_dw, clear, wenable, ovf_clr;
    logic [1:0] wsel;
    logic [3:0] wcount;
    logic [11:0] count0, count1;
    logic [2:0] carry0, carry1;
    logic ovf0, ovf1, werr0, werr1;
    int checks = 0;
    int errors = 0;
    int v[2];
    logic ovf_m[2];
    logic werr_m;

    cascade_counter #(.P_STAGES(3), .P_BIT(4), .P_BASE(base), .P_SAT(0), .P_SEL_W(2)) dut_wrap (
        .clk(clk), .resetn(resetn), .enable(enable), .up_dw(up_dw), .clear(clear),
        .wenable(wenable), .wsel(wsel), .wcount(wcount), .count(count0), .carry(carry0),
        .ovf(ovf0), .ovf_clr(ovf_clr), .werr(werr0));

    cascade_counter #(.P_STAGES(3), .P_BIT(4), .P_BASE(base), .P_SAT(1), .P_SEL_W(2)) dut_sat (
        .clk(clk), .resetn(resetn), .enable(enable), .up_dw(up_dw), .clear(clear),
        .wenable(wenable), .wsel(wsel), .wcount(wcount), .count(count1), .carry(carry1),
        .ovf(ovf1), .ovf_clr(ovf_clr), .werr(werr1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pb(input int i);
        int p = 1;
        for (int k = 0; k < i; k++) p *= mm[k];
        return p;
    endfunction

    function automatic logic [11:0] pack(input int x);
        logic [11:0] r = '0;
        for (int k = 0; k < 3; k++) r[k*4 +: 4] = 4'((x / pb(k)) % mm[k]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        check("count wrap", 32'(count0), 32'(pack(v[0])));
        check("count sat", 32'(count1), 32'(pack(v[1])));
        check("ovf wrap", 32'(ovf0), 32'(ovf_m[0]));
        check("ovf sat", 32'(ovf1), 32'(ovf_m[1]));
        check("werr wrap", 32'(werr0), 32'(werr_m));
        check("werr sat", 32'(werr1), 32'(werr_m));
    endtask

    // called just after a falling edge; returns just after the next falling edge
    task automatic step(input logic en, input logic ud, input logic clr, input logic we,
                        input logic [1:0] ws, input logic [3:0] wc, input logic oc);
        logic vwr;
        logic [2:0] ec[2];
        int total;
        total = pb(3);
        enable = en; up_dw = ud; clear = clr; wenable = we; wsel = ws; wcount = wc; ovf_clr = oc;
        #1;
        vwr = 1'b0;
        if (we && ws < 2'd3) vwr = int'(wc) < mm[ws];
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 3; i++)
                ec[s][i] = en && !clr && !vwr &&
                           (ud ? (v[s] % pb(i + 1)) == pb(i + 1) - 1 : (v[s] % pb(i + 1)) == 0);
        check("carry wrap", 32'(carry0), 32'(ec[0]));
        check("carry sat", 32'(carry1), 32'(ec[1]));
        @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            if (clr) begin
                v[s] = 0;
                ovf_m[s] = 1'b0;
            end else if (vwr) begin
                v[s] = v[s] - ((v[s] / pb(ws)) % mm[ws]) * pb(ws) + int'(wc) * pb(ws);
            end else begin
                if (en && !(s == 1 && ec[s][2])) v[s] = ud ? (v[s] + 1) % total : (v[s] + total - 1) % total;
                ovf_m[s] = ec[s][2] || (ovf_m[s] && !oc);
            end
        end
        werr_m = !clr && we && !vwr;
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic async_reset();
        resetn = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            v[s] = 0;
            ovf_m[s] = 1'b0;
        end
        werr_m = 1'b0;
        check_regs();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic load959();
        step(0, 1, 0, 1, 2'd0, 4'd9, 0);
        step(0, 1, 0, 1, 2'd1, 4'd5, 0);
        step(0, 1, 0, 1, 2'd2, 4'd9, 0);
    endtask

    initial begin
        resetn = 1'b0; enable = 0; up_dw = 1; clear = 0; wenable = 0; wsel = 0; wcount = 0; ovf_clr = 0;
        async_reset();
        for (int i = 0; i < 60; i++) step(1, 1, 0, 0, 2'd0, 4'd0, 0);
        check("after 60 up", 32'(count0), 32'h100);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 2'd0, 4'd0, 0);
        async_reset();
        load959();
        step(1, 1, 0, 0, 2'd0, 4'd0, 0);
        check("wrap to zero", 32'(count0), 32'h000);
        check("sat hold", 32'(count1), 32'h959);
        step(0, 1, 1, 0, 2'd0, 4'd0, 0);
        step(1, 0, 0, 0, 2'd0, 4'd0, 0);
        check("down wrap", 32'(count0), 32'h959);
        step(0, 1, 1, 0, 2'd0, 4'd0, 0);
        step(1, 1, 0, 1, 2'd0, 4'd10, 0);
        check("reject count", 32'(count0), 32'h001);
        step(0, 1, 0, 1, 2'd3, 4'd2, 0);
        step(1, 1, 0, 1, 2'd1, 4'd4, 0);
        step(0, 1, 1, 1, 2'd1, 4'd3, 0);
        load959();
        step(1, 1, 0, 0, 2'd0, 4'd0, 0);
        load959();
        step(1, 1, 0, 0, 2'd0, 4'd0, 1);
        check("ovf set wins", 32'(ovf0), 32'd1);
        step(0, 1, 0, 0, 2'd0, 4'd0, 1);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 99) < 3,
                 $urandom_range(0, 9) == 0, 2'($urandom), 4'($urandom),
                 $urandom_range(0, 9) == 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
